// File: rtl/oddeven_tally_if.sv
// oddeven_tally_if: sample input, flush and summary output handshake bundle for oddeven_tally
interface oddeven_tally_if #(parameter int FRAME_LEN = 8);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  logic in_valid;
  logic in_ready;
  logic [3:0] in_data;
  logic [3:0] in_parity;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [CNT_W-1:0] odd_cnt;
  logic [CNT_W-1:0] even_cnt;
  logic [CNT_W-1:0] max_odd_run;
  logic [CNT_W-1:0] frame_len;
  logic err;
  modport master(
    output in_valid, in_data, in_parity, flush, out_ready,
    input in_ready, out_valid, odd_cnt, even_cnt, max_odd_run, frame_len, err
  );
  modport slave(
    input in_valid, in_data, in_parity, flush, out_ready,
    output in_ready, out_valid, odd_cnt, even_cnt, max_odd_run, frame_len, err
  );
endinterface

// File: rtl/oddeven_tally.sv
// oddeven_tally: per-frame odd/even/longest-odd-run tally with registered summary; ODDEVEN_CHECK_EN adds parity/data checking
module oddeven_tally #(
  parameter int FRAME_LEN = 8
) (
  input logic clk,
  input logic rst_n,
  oddeven_tally_if.slave b
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  typedef enum logic {ACCUM, REPORT} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt_odd, cnt_even, cur_run, max_run;
  logic [CNT_W-1:0] n_odd, n_even, n_run, n_max, n_total;
  logic err_flag, n_err, acc, odd, close;
  assign acc = b.in_valid && state == ACCUM;
  assign odd = b.in_parity[0];
  assign b.in_ready = state == ACCUM;
  assign b.out_valid = state == REPORT;
  // next tally values including any sample accepted this cycle, and the frame-close decision
  always_comb begin
    n_odd = cnt_odd + CNT_W'(acc && odd);
    n_even = cnt_even + CNT_W'(acc && !odd);
    n_run = acc ? (odd ? cur_run + CNT_W'(1) : '0) : cur_run;
    n_max = n_run > max_run ? n_run : max_run;
    n_total = n_odd + n_even;
`ifdef ODDEVEN_CHECK_EN
    n_err = err_flag || (acc && b.in_parity != {3'b000, b.in_data[0]});
`else
    n_err = 1'b0;
`endif
    close = state == ACCUM && ((acc && n_total == CNT_W'(FRAME_LEN)) || (b.flush && n_total != '0));
  end
  // next state: close a frame into REPORT, return to ACCUM on summary handshake
  always_comb begin
    state_nx = state;
    if (close) state_nx = REPORT;
    else if (state == REPORT && b.out_ready) state_nx = ACCUM;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else state <= state_nx;
  end
  // tally counters clear when a frame closes; summary registers load only on that edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_odd <= '0;
      cnt_even <= '0;
      cur_run <= '0;
      max_run <= '0;
      err_flag <= 1'b0;
      b.odd_cnt <= '0;
      b.even_cnt <= '0;
      b.max_odd_run <= '0;
      b.frame_len <= '0;
      b.err <= 1'b0;
    end else if (close) begin
      cnt_odd <= '0;
      cnt_even <= '0;
      cur_run <= '0;
      max_run <= '0;
      err_flag <= 1'b0;
      b.odd_cnt <= n_odd;
      b.even_cnt <= n_even;
      b.max_odd_run <= n_max;
      b.frame_len <= n_total;
      b.err <= n_err;
    end else if (state == ACCUM) begin
      cnt_odd <= n_odd;
      cnt_even <= n_even;
      cur_run <= n_run;
      max_run <= n_max;
      err_flag <= n_err;
    end
  end
endmodule

// File: tb/tb_oddeven_tally.sv
// tb_oddeven_tally: directed self-checking bench for oddeven_tally
module tb_oddeven_tally;
`ifdef ODDEVEN_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_bad = 0;
  oddeven_tally_if #(.FRAME_LEN(8)) b();
  oddeven_tally #(.FRAME_LEN(8)) dut(.clk(clk), .rst_n(rst_n), .b(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] d, input logic [3:0] p, input logic fl);
    chk("in_ready_before_send", int'(b.in_ready), 1);
    b.in_valid = 1'b1;
    b.in_data = d;
    b.in_parity = p;
    b.flush = fl;
    tick();
    b.in_valid = 1'b0;
    b.flush = 1'b0;
  endtask
  task automatic sendv(input logic [3:0] d);
    send(d, {3'b000, d[0]}, 1'b0);
  endtask
  task automatic summary(input string tag, input int o, input int e, input int m, input int l, input int er);
    chk({tag, "_valid"}, int'(b.out_valid), 1);
    chk({tag, "_odd"}, int'(b.odd_cnt), o);
    chk({tag, "_even"}, int'(b.even_cnt), e);
    chk({tag, "_maxrun"}, int'(b.max_odd_run), m);
    chk({tag, "_len"}, int'(b.frame_len), l);
    chk({tag, "_err"}, int'(b.err), er);
  endtask
  task automatic ack();
    b.out_ready = 1'b1;
    tick();
    b.out_ready = 1'b0;
    chk("ack_out_valid", int'(b.out_valid), 0);
    chk("ack_in_ready", int'(b.in_ready), 1);
  endtask
  initial begin
    logic [3:0] v1 [8] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd4, 4'd9, 4'd11};
    logic [3:0] v2 [8] = '{4'd1, 4'd3, 4'd5, 4'd2, 4'd7, 4'd9, 4'd11, 4'd13};
    b.in_valid = 1'b0;
    b.in_data = '0;
    b.in_parity = '0;
    b.flush = 1'b0;
    b.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", int'(b.in_ready), 1);
    chk("rst_out_valid", int'(b.out_valid), 0);
    chk("rst_odd", int'(b.odd_cnt), 0);
    chk("rst_len", int'(b.frame_len), 0);
    for (int i = 0; i < 8; i++) begin
      chk("f1_no_early_valid", int'(b.out_valid), 0);
      sendv(v1[i]);
    end
    summary("f1", 6, 2, 3, 8, 0);
    b.in_valid = 1'b1;
    b.in_data = 4'd1;
    b.in_parity = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", int'(b.in_ready), 0);
      chk("bp_out_valid", int'(b.out_valid), 1);
      chk("bp_odd", int'(b.odd_cnt), 6);
      chk("bp_maxrun", int'(b.max_odd_run), 3);
    end
    b.in_valid = 1'b0;
    ack();
    sendv(4'd1);
    sendv(4'd3);
    send(4'd2, 4'd0, 1'b1);
    summary("flush", 2, 1, 2, 3, 0);
    ack();
    b.flush = 1'b1;
    tick();
    b.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_flush_no_valid", int'(b.out_valid), 0);
      tick();
    end
    for (int i = 0; i < 8; i++) sendv(4'd1);
    summary("all_odd", 8, 0, 8, 8, 0);
    ack();
    for (int i = 0; i < 8; i++) sendv(4'd2);
    summary("all_even", 0, 8, 0, 8, 0);
    ack();
    for (int i = 0; i < 4; i++) sendv(4'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", int'(b.out_valid), 0);
    chk("midrst_in_ready", int'(b.in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      chk("f2_no_early_valid", int'(b.out_valid), 0);
      sendv(v2[i]);
    end
    summary("after_rst", 7, 1, 4, 8, 0);
    ack();
    send(4'b0011, 4'b0000, 1'b1);
    summary("bad_par", 0, 1, 0, 1, CHK);
    ack();
    send(4'd5, 4'd1, 1'b1);
    summary("clean_par", 1, 0, 1, 1, 0);
    ack();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
